// File: rtl/mem_ctrl_arb_pkg.sv
// Shared types and helpers for the multi-port memory controller front-end.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        OKAY  = 2'b00,
        ERROR = 2'b01
    } resp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_t;

    // Index width for a count of n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_ctrl_arb_if.sv
// Request channels plus SRAM port of the memory controller front-end.
// master = bus subordinates / SRAM macro side, slave = the controller.
interface mem_ctrl_arb_if
    import mem_ctrl_pkg::*;
#(
    parameter int NumPorts  = 2,
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32,
    parameter int MemWords  = 1024
) ();
    localparam int StrbWidth    = DataWidth / 8;
    localparam int MemAddrWidth = idx_width(MemWords);

    logic [NumPorts-1:0]                 req;
    logic [NumPorts-1:0][AddrWidth-1:0]  addr;
    logic [NumPorts-1:0]                 write;
    logic [NumPorts-1:0][DataWidth-1:0]  wData;
    logic [NumPorts-1:0][StrbWidth-1:0]  wStrb;
    logic [NumPorts-1:0]                 done;
    logic [1:0]                          resp;
    logic [DataWidth-1:0]                rData;
    logic                                busy;

    logic                                mem_en;
    logic                                mem_we;
    logic [MemAddrWidth-1:0]             mem_addr;
    logic [DataWidth-1:0]                mem_wData;
    logic [StrbWidth-1:0]                mem_wStrb;
    logic [DataWidth-1:0]                mem_rData;

    modport master (
        output req, addr, write, wData, wStrb, mem_rData,
        input  done, resp, rData, busy,
        input  mem_en, mem_we, mem_addr, mem_wData, mem_wStrb
    );

    modport slave (
        input  req, addr, write, wData, wStrb, mem_rData,
        output done, resp, rData, busy,
        output mem_en, mem_we, mem_addr, mem_wData, mem_wStrb
    );

endinterface

// File: rtl/mem_ctrl_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// priority pointer; the pointer moves past the winner only when told to.
module rr_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int NumPorts = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NumPorts-1:0] req_i,
    input  logic                upd_i,
    output logic [NumPorts-1:0] gnt_o
);
    localparam int PtrW = idx_width(NumPorts);

    logic [PtrW-1:0] ptr_q;
    logic [PtrW-1:0] ptr_d;
    logic [PtrW-1:0] win_s;
    logic [PtrW:0]   raw_s;
    logic [PtrW:0]   idx_s;
    logic            hit_s;
    logic            found_s;

    // Wrapping search from the pointer; the first hit wins.
    always_comb begin
        win_s   = ptr_q;
        found_s = 1'b0;
        raw_s   = '0;
        idx_s   = '0;
        hit_s   = 1'b0;
        for (int i = 0; i < NumPorts; i++) begin
            raw_s   = {1'b0, ptr_q} + (PtrW + 1)'(i);
            idx_s   = (raw_s >= (PtrW + 1)'(NumPorts)) ? raw_s - (PtrW + 1)'(NumPorts) : raw_s;
            hit_s   = !found_s && req_i[idx_s[PtrW-1:0]];
            win_s   = hit_s ? idx_s[PtrW-1:0] : win_s;
            found_s = found_s | hit_s;
        end
        gnt_o = found_s ? (NumPorts'(1'b1) << win_s) : '0;
        if (upd_i && found_s) begin
            ptr_d = (win_s == PtrW'(NumPorts - 1)) ? '0 : win_s + PtrW'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Priority pointer register; port 0 has top priority out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_ctrl_arb.sv
// Multi-port SRAM front-end: round-robin arbitration, range check, one
// transaction at a time, read latency counter and registered outputs.
// The ISSUE-cycle mem_* registers are loaded at grant, so they hold the
// latched request; port changes after the grant never reach the SRAM.
module mem_ctrl_arb
    import mem_ctrl_pkg::*;
#(
    parameter int NumPorts    = 2,
    parameter int DataWidth   = 32,
    parameter int AddrWidth   = 32,
    parameter int MemWords    = 1024,
    parameter int ReadLatency = 1
) (
    input  logic           clk,
    input  logic           reset,
    mem_ctrl_arb_if.slave  bus
);
    localparam int StrbW = DataWidth / 8;
    localparam int OffW  = $clog2(StrbW);
    localparam int MemAw = idx_width(MemWords);
    localparam int CntW  = idx_width(ReadLatency);

    state_t                state_q, state_d;
    logic [NumPorts-1:0]   gnt_s, gnt_q, gnt_d;
    logic                  we_q, we_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  arb_upd_s;

    logic [AddrWidth-1:0]  sel_addr_s;
    logic                  sel_write_s;
    logic [DataWidth-1:0]  sel_wdata_s;
    logic [StrbW-1:0]      sel_wstrb_s;
    logic [AddrWidth-1:0]  word_s;
    logic                  err_s;

    logic [NumPorts-1:0]   done_q, done_d;
    resp_t                 resp_q, resp_d;
    logic [DataWidth-1:0]  rdata_q, rdata_d;
    logic                  busy_q, busy_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [MemAw-1:0]      mem_addr_q, mem_addr_d;
    logic [DataWidth-1:0]  mem_wdata_q, mem_wdata_d;
    logic [StrbW-1:0]      mem_wstrb_q, mem_wstrb_d;

    assign arb_upd_s = (state_q == IDLE) && (|bus.req);

    rr_arbiter #(
        .NumPorts (NumPorts)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req_i (bus.req),
        .upd_i (arb_upd_s),
        .gnt_o (gnt_s)
    );

    // AND-OR mux of the granted port's request fields plus range check.
    always_comb begin
        sel_addr_s  = '0;
        sel_write_s = 1'b0;
        sel_wdata_s = '0;
        sel_wstrb_s = '0;
        for (int i = 0; i < NumPorts; i++) begin
            sel_addr_s  = sel_addr_s  | (bus.addr[i]  & {AddrWidth{gnt_s[i]}});
            sel_write_s = sel_write_s | (bus.write[i] & gnt_s[i]);
            sel_wdata_s = sel_wdata_s | (bus.wData[i] & {DataWidth{gnt_s[i]}});
            sel_wstrb_s = sel_wstrb_s | (bus.wStrb[i] & {StrbW{gnt_s[i]}});
        end
        word_s = sel_addr_s >> OffW;
        err_s  = (word_s >= AddrWidth'(MemWords));
    end

    // FSM next state and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        done_d      = '0;
        resp_d      = OKAY;
        rdata_d     = '0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_wstrb_d = '0;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    gnt_d = gnt_s;
                    we_d  = sel_write_s;
                    if (err_s) begin
                        state_d = RESP;
                        done_d  = gnt_s;
                        resp_d  = ERROR;
                    end else begin
                        state_d     = ISSUE;
                        mem_en_d    = 1'b1;
                        mem_we_d    = sel_write_s;
                        mem_addr_d  = word_s[MemAw-1:0];
                        mem_wdata_d = sel_wdata_s;
                        mem_wstrb_d = sel_write_s ? sel_wstrb_s : '0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = RESP;
                    done_d  = gnt_q;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CntW'(ReadLatency - 1);
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    done_d  = gnt_q;
                    rdata_d = bus.mem_rData;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, latched grant/direction, latency counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            done_q      <= '0;
            resp_q      <= OKAY;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            resp_q      <= resp_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    assign bus.done      = done_q;
    assign bus.resp      = resp_q;
    assign bus.rData     = rdata_q;
    assign bus.busy      = busy_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wData = mem_wdata_q;
    assign bus.mem_wStrb = mem_wstrb_q;

endmodule

// File: doc/mem_ctrl_arb.md
# mem_ctrl_arb

Parametrised multi-port memory controller front-end: arbitrates `NumPorts` subordinate-side request channels round-robin onto one synchronous SRAM port and returns `resp`/`rData` to the winner. It is the next generation of the common memory-controller signal set, adding:
- multiple channels;
- byte write strobes;
- configurable read latency;
- range-checked ERROR responses;
- an explicit request/done handshake.

It sits between the bus subordinates and the on-chip SRAM macro.

## Interface
- `NumPorts`, 2: request channels, ≥1.
- `DataWidth`, 32: data bits, multiple of 8.
- `AddrWidth`, 32: byte-address bits.
- `MemWords`, 1024: SRAM depth in words.
- `ReadLatency`, 1: SRAM cycles from enable to read data, ≥1.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  NumPorts  per-port request, held until `done`.
- `addr`  in  NumPorts×AddrWidth  per-port byte address.
- `write`  in  NumPorts  per-port direction: 1 = write, 0 = read.
- `wData`  in  NumPorts×DataWidth  per-port write data.
- `wStrb`  in  NumPorts×DataWidth/8  per-port byte enables.
- `done`  out  NumPorts  one-cycle completion pulse, one-hot.
- `resp`  out  2  response for the completing port (`OKAY`=00, `ERROR`=01).
- `rData`  out  DataWidth  read data for the completing port.
- `busy`  out  1  high whenever state ≠ IDLE.
- `mem_en`  out  1  SRAM enable.
- `mem_we`  out  1  SRAM write enable.
- `mem_addr`  out  $clog2(MemWords)  SRAM word address.
- `mem_wData`  out  DataWidth  SRAM write data.
- `mem_wStrb`  out  DataWidth/8  SRAM byte enables.
- `mem_rData`  in  DataWidth  SRAM read data.

## Operation
- **Reset values:** all outputs 0; state IDLE; round-robin pointer → port 0 highest priority.
- **Asynchronous reset mid-transaction:** aborts immediately. No `done` is issued, and any SRAM read in flight is discarded.
- **Word address:** `addr >> $clog2(DataWidth/8)`. Low byte-offset bits are ignored, and byte selection is by `wStrb` only.
- **Range check:** a request is ERROR if its word address ≥ `MemWords`. An ERROR request never asserts `mem_en`.
- **Arbitration:**
  - Round-robin: search starts at the port after the last granted port, wrapping.
  - The pointer updates only on a grant.
  - An ERROR grant counts as a grant.
- **Latching:** on grant, `addr`/`write`/`wData`/`wStrb` are latched. Later changes on the port, including dropping `req`, are ignored, and the transaction still completes with a `done` pulse.
- **States:**
  - IDLE: no `req` → stay. Any `req` → grant, latch, go to ISSUE (in range) or RESP (ERROR).
  - ISSUE: `mem_en`=1, `mem_we`=latched `write`, `mem_*` from latches. Write → RESP. Read → WAIT with counter = `ReadLatency`−1.
  - WAIT: if counter = 0, capture `mem_rData` into `rData` and go to RESP; else decrement.
  - RESP: `done[grant]`=1, `resp`, and `rData` valid for exactly this cycle → IDLE.
- **Output values outside ISSUE/RESP:**
  - `mem_en`/`mem_we` are 0 outside ISSUE.
  - `rData` is 0 for writes and ERROR.
  - `done` and `resp` are 0 outside RESP.
- **Unused strobe bits:** a read ignores `wStrb`, and `mem_wStrb` is 0 on reads.
- **Re-request:** a `req` still high in the cycle after RESP is a new request, arbitrated normally.

## Timing
Request first seen in IDLE at cycle 0.
- **Write:** ISSUE at c1, RESP/`done` at c2. Latency 2.
- **Read:**
  - ISSUE at c1.
  - SRAM data valid during c1+`ReadLatency`, captured at the end of that cycle.
  - `done` at c2+`ReadLatency`.
  - Latency 3 when `ReadLatency`=1.
- **ERROR:** `done` at c1.
- **Back-to-back requests:** no overlap. The next grant is earliest in the IDLE cycle after RESP, so throughput is one transaction per latency+1 cycles.

## Structure
- **Package `mem_ctrl_pkg`:**
  - `resp_t` enum (`OKAY`=2'b00, `ERROR`=2'b01).
  - `state_t` enum (IDLE, ISSUE, WAIT, RESP).
- **Sub-module `rr_arbiter`** (parametrised `NumPorts`):
  - inputs: request vector, update enable;
  - output: one-hot grant;
  - internal: the priority pointer, reset to port 0.
- **Top level:** FSM, latches and latency counter.

## Test plan
- **Reset:** assert `reset` mid-WAIT → all outputs 0 immediately. After release with no `req`, no `done`; the next grant goes to port 0.
- **Write then read:** port 0 writes `addr`=0x10, `wData`=0xDEADBEEF, `wStrb`=4'b0101.
  - Write: `mem_addr`=4, `mem_we`=1 at c1, `done[0]` at c2, `resp`=00.
  - Read back (SRAM model): `rData`=0x00AD00EF, with `done` at c2+`ReadLatency`.
- **Round-robin:** ports 0 and 1 request simultaneously and continuously.
  - Grants alternate 0,1,0,1.
  - With 3 ports and port 1 idle, grants alternate 0,2,0,2.
- **Range error:** `addr`=`MemWords`×4 → `done` at c1, `resp`=01, `rData`=0, `mem_en` never high. The following request is still served.
- **Latency sweep:** for `ReadLatency`=1 and 4, read latency is 3 and 6 respectively. Dropping `req` after grant still yields exactly one `done`.
- **Held inputs:** port changes `addr`/`wData` during WAIT → `mem_*` and `rData` reflect the latched values only.
